reg_lock_tracker: RTL and testbench
===================================

# reg_lock_tracker

Scoreboard that produces the per-register `locks` vector consumed by `instr_launcher`. It sits on the far side of the launch interface: it observes every instruction that leaves the launcher and locks that instruction's destination register. It observes every writeback and releases the lock. It tracks multiple outstanding writes per register and a global in-flight limit, and back-pressures launch when either limit is reached.

## Interface

Parameters:
- `NUM_REGS`, `maverickOne_pkg::NUM_REGS`: number of architectural registers (≥2).
- `MAX_PENDING`, 3: maximum outstanding writes to one register (≥1).
- `MAX_INFLIGHT`, `maverickOne_pkg::NUM_OUTSTANDING + 1`: maximum outstanding writes across all registers (≥1).
- `RW`, `$clog2(NUM_REGS)`: register index width (derived).

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `clear_i`  in  1  synchronous flush; drops all locks.
- `launch_valid_i`  in  1  an instruction is offered on the launch interface.
- `launch_ready_o`  out  1  the tracker can accept the offered instruction.
- `launch_rd_i`  in  RW  destination register of the offered instruction.
- `launch_wr_en_i`  in  1  the offered instruction writes `launch_rd_i`.
- `wb_valid_i`  in  1  a writeback is completing.
- `wb_rd_i`  in  RW  register being written back.
- `locks_o`  out  NUM_REGS  bit r = 1 while register r has an outstanding write (drives launcher `locks_i`).
- `inflight_o`  out  `$clog2(MAX_INFLIGHT+1)`  total outstanding writes.
- `error_o`  out  1  sticky flag; a writeback arrived for an unlocked register.

## Operation

- State:
  - one counter `cnt[r]` per register, width `$clog2(MAX_PENDING+1)`;
  - counter `inflight`, equal to the sum of all `cnt[r]`;
  - sticky `err`.
- A launch is accepted when `launch_valid_i & launch_ready_o`.
- A launch is counted (a "write launch") when it is accepted, `launch_wr_en_i = 1`, and `launch_rd_i != 0`.
  - Register 0 is hardwired zero. It is never locked and never counted.
- `launch_ready_o` is a function of current state and the launch inputs only:
  - `!rst_i & !clear_i & (!launch_wr_en_i | launch_rd_i == 0 | (cnt[launch_rd_i] < MAX_PENDING & inflight < MAX_INFLIGHT))`.
  - It does not depend on `launch_valid_i` or any writeback input.
- Writeback is always accepted; there is no ready signal.
  - A writeback is valid when `wb_valid_i & wb_rd_i != 0 & cnt[wb_rd_i] != 0`.
  - `wb_valid_i` with `wb_rd_i == 0` is ignored with no error.
  - `wb_valid_i` with `wb_rd_i != 0` and `cnt[wb_rd_i] == 0` is ignored and sets `err`.
- Counter update per register r:
  - +1 on a write launch to r;
  - −1 on a valid writeback to r;
  - both in the same cycle: unchanged.
  - `inflight` follows the same rules, summed across registers.
- Launch and writeback to different registers in the same cycle update both counters independently.
- `locks_o[r] = (cnt[r] != 0)`, decoded from registered state. `locks_o[0]` is constant 0.
- `inflight_o = inflight`; `error_o = err`.
- Priority: `rst_i` > `clear_i` > launch/writeback.
  - `clear_i` zeroes all `cnt[r]` and `inflight`.
  - `clear_i` does not clear `err`; only `rst_i` clears `err`.
  - Launch and writeback in a clear cycle are discarded.
- Index range: `launch_rd_i` and `wb_rd_i` values ≥ NUM_REGS (when NUM_REGS is not a power of 2) are treated like register 0.

## Timing

- Reset values: `locks_o = 0`, `inflight_o = 0`, `error_o = 0`, `launch_ready_o = 0` while `rst_i = 1`. `launch_ready_o` is 1 in the first cycle after reset deasserts.
- Latency:
  - An accepted write launch in cycle N raises `locks_o[rd]` and `inflight_o` at cycle N+1.
  - A writeback in cycle N drops the lock at N+1 if the count reaches 0.
- There is no combinational path from launch or writeback inputs to `locks_o`. The launcher therefore sees its own launch lock one cycle later and must not issue a dependent instruction in that cycle.
- A register with `cnt = MAX_PENDING` deasserts `launch_ready_o` only for write launches to that register. A same-cycle writeback to it does not bypass; ready returns the next cycle.
- Global full (`inflight = MAX_INFLIGHT`) blocks all write launches. Non-writing launches and launches to register 0 remain ready.
- Reset mid-operation: all state is zero on the next edge. Writebacks arriving after that edge for pre-reset launches set `err`.

## Test plan

- **Reset:** hold `rst_i` 3 cycles with random inputs → `locks_o = 0`, `inflight_o = 0`, `error_o = 0`, `launch_ready_o = 0`. Release → `launch_ready_o = 1`.
- **Single lock/unlock:** launch rd=5 with wr_en=1 → cycle+1 `locks_o = 0x20`, `inflight_o = 1`. Writeback rd=5 → cycle+1 `locks_o = 0`, `inflight_o = 0`.
- **Per-register saturation:** with defaults, launch rd=7 three times → fourth offer to rd=7 gives `launch_ready_o = 0`; an offer to rd=8 gives 1. Three writebacks to rd=7 → `locks_o[7]` clears only after the third.
- **Global full:** with MAX_INFLIGHT=4, launch rd=1..4 → `inflight_o = 4`. Offer rd=9 with wr_en=1 → ready 0. Offer wr_en=0 → ready 1. Offer rd=0 → ready 1 and `locks_o[0]` stays 0.
- **Simultaneous events:** `cnt[3] = 1`; same cycle launch rd=3 and writeback rd=3 → `cnt` and `locks_o[3]` unchanged, `inflight` unchanged. Launch rd=2 with writeback rd=3 → `locks_o` bit 2 set, bit 3 cleared.
- **Errors and clear:**
  - Writeback rd=6 while unlocked → `error_o = 1` next cycle and stays 1.
  - `clear_i` with 3 locks held plus a same-cycle launch → `locks_o = 0`, `inflight_o = 0`, `error_o` still 1, launch not counted.
  - `rst_i` → `error_o = 0`.

Source files
------------

// File: rtl/reg_lock_tracker.sv
// Destination-register lock scoreboard: counts outstanding writes per register
// and in total, and back-pressures launch when either count is full.
package maverickOne_pkg;
    localparam int NUM_REGS        = 32;
    localparam int NUM_OUTSTANDING = 3;
endpackage

module reg_lock_tracker #(
    parameter int NUM_REGS     = maverickOne_pkg::NUM_REGS,
    parameter int MAX_PENDING  = 3,
    parameter int MAX_INFLIGHT = maverickOne_pkg::NUM_OUTSTANDING + 1,
    parameter int RW           = $clog2(NUM_REGS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              launch_valid_i,
    output logic                              launch_ready_o,
    input  logic [RW-1:0]                     launch_rd_i,
    input  logic                              launch_wr_en_i,
    input  logic                              wb_valid_i,
    input  logic [RW-1:0]                     wb_rd_i,
    output logic [NUM_REGS-1:0]               locks_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
    output logic                              error_o
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);
    localparam logic [IW-1:0] FLY_MAX  = IW'(MAX_INFLIGHT);

    // Register 0 has no counter; it can never be locked.
    logic [CW-1:0]          cnt [1:NUM_REGS-1];
    logic [IW-1:0]          inflight;
    logic                   err;

    logic                   l_hit;
    logic                   w_hit;
    logic [CW-1:0]          l_cnt;
    logic [CW-1:0]          w_cnt;
    logic                   wr_launch;
    logic                   wb_ok;
    logic                   wb_bad;
    logic [NUM_REGS-1:1]    inc;
    logic [NUM_REGS-1:1]    dec;

    // Out-of-range indices simply never match, so they behave like register 0.
    always_comb begin
        l_hit = 1'b0;
        w_hit = 1'b0;
        l_cnt = '0;
        w_cnt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (launch_rd_i == RW'(r)) begin
                l_hit = 1'b1;
                l_cnt = cnt[r];
            end
            if (wb_rd_i == RW'(r)) begin
                w_hit = 1'b1;
                w_cnt = cnt[r];
            end
        end
    end

    always_comb begin
        launch_ready_o = !rst_i && !clear_i &&
                         (!launch_wr_en_i || !l_hit ||
                          (l_cnt < PEND_MAX && inflight < FLY_MAX));
        wr_launch = launch_valid_i && launch_ready_o &&
                    launch_wr_en_i && l_hit;
        wb_ok     = wb_valid_i && w_hit && (w_cnt != '0);
        wb_bad    = wb_valid_i && w_hit && (w_cnt == '0);
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc[r] = wr_launch && (launch_rd_i == RW'(r));
            dec[r] = wb_ok && (wb_rd_i == RW'(r));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            inflight <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec[r] && !inc[r]) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            if (wr_launch && !wb_ok) begin
                inflight <= inflight + 1'b1;
            end else if (wb_ok && !wr_launch) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    // A flush drops locks but keeps the error history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (!clear_i && wb_bad) begin
            err <= 1'b1;
        end
    end

    always_comb begin
        locks_o = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            locks_o[r] = (cnt[r] != '0);
        end
    end

    assign inflight_o = inflight;
    assign error_o    = err;

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Directed and random checks of reg_lock_tracker against a counting
// model of outstanding writes.
module tb_reg_lock_tracker;

    localparam int NR = 32;
    localparam int MP = 3;
    localparam int MI = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       lv;
    logic       lready;
    logic [4:0] lrd;
    logic       lwe;
    logic       wv;
    logic [4:0] wrd;
    logic [31:0] locks;
    logic [2:0] infl;
    logic       err;

    always #5 clk = ~clk;

    reg_lock_tracker #(
        .NUM_REGS    (NR),
        .MAX_PENDING (MP),
        .MAX_INFLIGHT(MI)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clr),
        .launch_valid_i(lv),
        .launch_ready_o(lready),
        .launch_rd_i   (lrd),
        .launch_wr_en_i(lwe),
        .wb_valid_i    (wv),
        .wb_rd_i       (wrd),
        .locks_o       (locks),
        .inflight_o    (infl),
        .error_o       (err)
    );

    int m_cnt [NR];
    int m_inf;
    bit m_err;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_locks();
        logic [31:0] v;
        v = '0;
        for (int r = 1; r < NR; r++) begin
            v[r] = (m_cnt[r] != 0);
        end
        return v;
    endfunction

    // One clock: drive at negedge, check ready, advance model, check state.
    task automatic cyc(input bit r_, input bit c_, input bit v_, input int ld,
                       input bit we, input bit bv, input int bd);
        bit exp_rdy;
        bit acc;
        bit ok;
        @(negedge clk);
        rst = r_;
        clr = c_;
        lv  = v_;
        lrd = ld[4:0];
        lwe = we;
        wv  = bv;
        wrd = bd[4:0];
        #1;
        exp_rdy = !r_ && !c_ &&
                  (!we || ld == 0 || (m_cnt[ld] < MP && m_inf < MI));
        chk("ready", {31'b0, lready}, {31'b0, exp_rdy});
        @(posedge clk);
        if (r_) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_inf = 0;
            m_err = 0;
        end else if (c_) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_inf = 0;
        end else begin
            acc = v_ && exp_rdy && we && ld != 0;
            ok  = bv && bd != 0 && m_cnt[bd] > 0;
            if (bv && bd != 0 && m_cnt[bd] == 0) m_err = 1;
            if (acc) begin
                m_cnt[ld]++;
                m_inf++;
            end
            if (ok) begin
                m_cnt[bd]--;
                m_inf--;
            end
        end
        #1;
        chk("locks", locks, m_locks());
        chk("inflight", {29'b0, infl}, m_inf);
        chk("error", {31'b0, err}, {31'b0, m_err});
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; lv = 1'b0; lrd = '0;
        lwe = 1'b0; wv = 1'b0; wrd = '0;
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_inf = 0;
        m_err = 0;

        // Reset with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            cyc(1, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 31), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 31));
        end
        chk("rst_locks", locks, 32'h0);
        cyc(0, 0, 0, 5, 1, 0, 0);

        // Single lock / unlock
        cyc(0, 0, 1, 5, 1, 0, 0);
        chk("lock5", locks, 32'h20);
        chk("infl1", {29'b0, infl}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 5);
        chk("unlock5", locks, 32'h0);

        // Per-register saturation
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 7, 1, 0, 0);
        cyc(0, 0, 1, 7, 1, 0, 0);
        cyc(0, 0, 0, 8, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 7);
        chk("l7_a", {31'b0, locks[7]}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 7);
        chk("l7_b", {31'b0, locks[7]}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 7);
        chk("l7_c", {31'b0, locks[7]}, 32'd0);

        // Global full
        for (int r = 1; r <= 4; r++) cyc(0, 0, 1, r, 1, 0, 0);
        chk("full", {29'b0, infl}, 32'd4);
        cyc(0, 0, 1, 9, 1, 0, 0);
        cyc(0, 0, 1, 9, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 0);
        chk("full_keep", locks, 32'h1e);
        for (int r = 1; r <= 4; r++) cyc(0, 0, 0, 0, 0, 1, r);

        // Simultaneous launch and writeback
        cyc(0, 0, 1, 3, 1, 0, 0);
        cyc(0, 0, 1, 3, 1, 1, 3);
        chk("same_reg", locks, 32'h8);
        cyc(0, 0, 1, 2, 1, 1, 3);
        chk("swap", locks, 32'h4);
        cyc(0, 0, 0, 0, 0, 1, 2);

        // Errors, clear, reset
        cyc(0, 0, 0, 0, 0, 1, 6);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", {31'b0, err}, 32'd1);
        for (int r = 1; r <= 3; r++) cyc(0, 0, 1, r + 10, 1, 0, 0);
        cyc(0, 1, 1, 5, 1, 0, 0);
        chk("clr_locks", locks, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_err", {31'b0, err}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1, 0);

        // Random traffic on a small register window
        for (int i = 0; i < 500; i++) begin
            int b;
            b = $urandom_range(0, 99);
            cyc(b == 0, b < 3, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9), $urandom_range(0, 4) != 0,
                $urandom_range(0, 1), $urandom_range(0, 9));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
